// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter: two-master, one-slave round-robin arbiter for the SoC
// memory bus. Master 0 is the UART bridge and master 1 is the core data port.
// The slave is the video controller framebuffer port.
//
// Ports:
//   clk, res        clock and synchronous active-high reset
//   mX_req/wr/addr/wdata/wstrb   request from master X; held until mX_ready
//   mX_ready/rdata/err           one-cycle completion pulse, read data, timeout error
//   s_req/wr/addr/wdata/wstrb    request forwarded from the current owner
//   s_ready/rdata                slave completion pulse and read data
//
// Optional feature: define SOC_ARB_TIMEOUT_EN to enable the slave-stall
// timeout of TIMEOUT_CYCLES cycles. Without it mX_err is tied to 0.
module soc_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    m0_req,
    input  logic                    m0_wr,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    output logic                    m0_ready,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic                    m0_err,
    input  logic                    m1_req,
    input  logic                    m1_wr,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    output logic                    m1_ready,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    m1_err,
    output logic                    s_req,
    output logic                    s_wr,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_rdata
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state, state_n;
    logic   owner, owner_n;     // 0 = UART bridge, 1 = core
    logic   last, last_n;       // master granted most recently
    logic   tmo;                // timeout fires this cycle
    logic   done;               // owner's transaction completes this cycle
    logic [DATA_WIDTH-1:0] resp_rdata;

`ifdef SOC_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt, cnt_n;

    // Stall counter: held at zero in IDLE so every grant starts from zero.
    always_ff @(posedge clk) begin
        if (res) cnt <= '0;
        else     cnt <= cnt_n;
    end

    always_comb begin
        cnt_n = cnt;
        if (state == IDLE)  cnt_n = '0;
        else if (!s_ready)  cnt_n = cnt + 1'b1;
    end

    // A slave answer in the limit cycle wins over the timeout.
    assign tmo = (state == BUSY) && !s_ready && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    // State, owner and round-robin history registers.
    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
        end
    end

    // Next-state: grant in IDLE, release on completion in BUSY.
    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        done    = (state == BUSY) && (s_ready || tmo);
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_n = BUSY;
                    // On a tie the master that did not win last time gets the bus.
                    owner_n = (m0_req && m1_req) ? ~last : m1_req;
                end
            end
            BUSY: begin
                if (done) begin
                    state_n = IDLE;
                    last_n  = owner;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Slave-side mux and master-side completion routing.
    always_comb begin
        s_req      = 1'b0;
        s_wr       = 1'b0;
        s_addr     = '0;
        s_wdata    = '0;
        s_wstrb    = '0;
        m0_ready   = 1'b0;
        m0_rdata   = '0;
        m0_err     = 1'b0;
        m1_ready   = 1'b0;
        m1_rdata   = '0;
        m1_err     = 1'b0;
        resp_rdata = tmo ? DATA_WIDTH'(32'hDEAD_BEEF) : s_rdata;

        if (state == BUSY) begin
            s_req   = 1'b1;
            s_wr    = owner ? m1_wr    : m0_wr;
            s_addr  = owner ? m1_addr  : m0_addr;
            s_wdata = owner ? m1_wdata : m0_wdata;
            s_wstrb = owner ? m1_wstrb : m0_wstrb;
        end

        // A reset cycle drops the transaction without a completion pulse.
        if (done && !res) begin
            if (owner) begin
                m1_ready = 1'b1;
                m1_rdata = resp_rdata;
                m1_err   = tmo;
            end else begin
                m0_ready = 1'b1;
                m0_rdata = resp_rdata;
                m0_err   = tmo;
            end
        end
    end

    logic unused_strb_width;
    assign unused_strb_width = (STRB_WIDTH == 0);

endmodule

// File: doc/soc_bus_arbiter.md
# soc_bus_arbiter

Two-master, one-slave round-robin arbiter for the SoC memory bus. It lets the UART bridge (debug/loader master) and the core data port share one slave, the video controller framebuffer port, without either master being starved. It sits between both masters and the video controller's framebuffer bus input. Every transaction passes through with one cycle of arbitration latency.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 1024, slave-stall limit in cycles; used only with SOC_ARB_TIMEOUT_EN

Ports (x = 0 for UART bridge, 1 for core):
- clk  in  1  main clock; the only clock
- res  in  1  synchronous, active-high reset
- mx_req  in  1  master x request; held high until its mx_ready pulse
- mx_wr  in  1  1 = write, 0 = read
- mx_addr  in  ADDR_WIDTH  byte address
- mx_wdata  in  DATA_WIDTH  write data
- mx_wstrb  in  DATA_WIDTH/8  byte enables
- mx_ready  out  1  one-cycle completion pulse to master x
- mx_rdata  out  DATA_WIDTH  read data, valid while mx_ready is high
- mx_err  out  1  timeout error, valid while mx_ready is high; constant 0 without SOC_ARB_TIMEOUT_EN
- s_req, s_wr, s_addr, s_wdata, s_wstrb  out  as master fields  forwarded request to slave
- s_ready  in  1  slave completion pulse
- s_rdata  in  DATA_WIDTH  slave read data

## Operation
- States:
  - IDLE: no owner; s_req = 0.
  - BUSY: owner is registered; s_req = 1; all s_* fields are muxed from the owner.
- IDLE, at least one mx_req high:
  - With one requester, grant it.
  - With both requesting, grant the master that is not `last`. `last` is a 1-bit register, reset to 1, so m0 wins the first tie.
  - Next state is BUSY with the owner registered.
- BUSY, s_ready high:
  - Assert m_owner_ready combinationally in the same cycle; m_owner_rdata = s_rdata.
  - Set last <= owner and go to IDLE.
  - s_req is low the following cycle.
- The non-owner's ready is never asserted, and its rdata is driven 0.
- A master is not allowed to drop mx_req or change its fields before its ready pulse. If it does while it owns the bus, the arbiter ignores the change and keeps the transaction running.
- s_ready arriving in IDLE is ignored.
- Transactions are never pipelined: at most one is outstanding at a time.

## Timing
- Reset values: s_req = 0, all s_* fields = 0, mx_ready = 0, mx_rdata = 0, mx_err = 0, state = IDLE, last = 1, timeout counter = 0.
- Reset asserted mid-transaction: the arbiter is IDLE on the next cycle and drops the transaction with no ready pulse. Masters must also be reset.
- Latency, cycle 0 = first cycle mx_req is high in IDLE:
  - s_req rises at cycle 1.
  - mx_ready coincides with s_ready.
  - Minimum total is 2 cycles when the slave answers in its first request cycle.
- Back-to-back: after a ready pulse there is one IDLE cycle before the next grant, so s_req has at least one low cycle between transactions.
- With both masters requesting continuously, grants strictly alternate: m0, m1, m0, ...
- Request fields are combinational muxes of the owner's inputs. The owner holding its fields stable guarantees s_* is stable for the whole grant.

## Configuration
- Macro: SOC_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments every BUSY cycle without s_ready.
  - When the counter reaches TIMEOUT_CYCLES-1 with s_ready low, the arbiter pulses m_owner_ready with m_owner_err = 1 and m_owner_rdata = 32'hDEAD_BEEF, sets last <= owner, and goes to IDLE.
  - s_ready in that same cycle takes precedence and produces a normal completion with err = 0.
- Undefined: no counter, BUSY waits indefinitely, mx_err is tied to 0.

## Test plan
- m0 read of address 0x0000_0010, slave returns 0x1234_5678 on its first request cycle -> s_req high at cycle 1 only; m0_ready and m0_rdata = 0x1234_5678 at cycle 1; m1_ready stays 0.
- m0 and m1 both request from reset -> m0 is granted first, then m1; grants alternate m0, m1, m0, m1 over 4 transactions, with an s_req low cycle between each.
- m1 write: addr 0x0000_0100, wdata 0xA5A5_A5A5, wstrb 0b0011; slave stalls 5 cycles -> s_* fields hold those values for all 6 request cycles; m1_ready pulses exactly once.
- Reset asserted during BUSY -> next cycle s_req = 0, no mx_ready pulse, last = 1; a following simultaneous request grants m0.
- With SOC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave never answers -> m0_ready = 1, m0_err = 1, m0_rdata = 0xDEAD_BEEF in the 8th BUSY cycle; a late s_ready in IDLE is ignored.
- With SOC_ARB_TIMEOUT_EN, s_ready arrives in the same cycle the timeout would fire -> normal completion, err = 0, rdata = s_rdata.
